alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_result_fifo_if.sv | 34 +++
 rtl/alu_flag_gen.sv | 13 +
 rtl/alu_result_fifo.sv | 93 +++++++++
 tb/tb_alu_result_fifo.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU widths and the result-entry record stored by alu_result_fifo.
// Flag fields are only populated when ALU_RES_FLAGS_EN is defined.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             cout;
        logic [SEL_W-1:0] sel;
        logic             zero;
        logic             neg;
    } alu_entry_t;

    // Entry layout used when flag storage is compiled out.
    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             cout;
        logic [SEL_W-1:0] sel;
    } alu_core_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Handshake and data bundle between an ALU producer, the result FIFO and its consumer.
// Both sides use valid/ready: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface alu_result_fifo_if #(
    parameter int DEPTH = 4
);
    import alu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [ALU_W-1:0] alu_out;
    logic             alu_cout;
    logic [SEL_W-1:0] alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [ALU_W-1:0] out_data;
    logic             out_cout;
    logic [SEL_W-1:0] out_sel;
    logic             out_zero;
    logic             out_neg;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, alu_out, alu_cout, alu_sel, out_ready,
        input  in_ready, out_valid, out_data, out_cout, out_sel, out_zero, out_neg, count
    );

    modport slave (
        input  in_valid, alu_out, alu_cout, alu_sel, out_ready,
        output in_ready, out_valid, out_data, out_cout, out_sel, out_zero, out_neg, count
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag generation for one ALU result byte.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] data,
    output logic             zero,
    output logic             neg
);

    assign zero = (data == '0);
    assign neg  = data[ALU_W-1];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO of ALU results with occupancy count.
// Define ALU_RES_FLAGS_EN to compute and store zero/negative flags per entry.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_fifo_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic          not_empty;

    // Ready and valid depend only on the registered count, so nothing here
    // combinationally reaches from an input to an output.
    assign not_empty     = (count_q != '0);
    assign bus.in_ready  = (count_q < FULL_CNT);
    assign bus.out_valid = not_empty;
    assign bus.count     = count_q;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_ready && not_empty;

`ifdef ALU_RES_FLAGS_EN
    alu_entry_t mem [DEPTH];
    alu_entry_t wr_entry;
    logic       zero_w;
    logic       neg_w;

    alu_flag_gen u_flag_gen (
        .data (bus.alu_out),
        .zero (zero_w),
        .neg  (neg_w)
    );

    assign wr_entry = '{data: bus.alu_out, cout: bus.alu_cout, sel: bus.alu_sel,
                        zero: zero_w, neg: neg_w};
`else
    alu_core_t mem [DEPTH];
    alu_core_t wr_entry;

    assign wr_entry = '{data: bus.alu_out, cout: bus.alu_cout, sel: bus.alu_sel};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head fields are forced to zero while empty so stale entries never leak.
    always_comb begin
        bus.out_data = '0;
        bus.out_cout = 1'b0;
        bus.out_sel  = '0;
        bus.out_zero = 1'b0;
        bus.out_neg  = 1'b0;
        if (not_empty) begin
            bus.out_data = mem[rd_ptr].data;
            bus.out_cout = mem[rd_ptr].cout;
            bus.out_sel  = mem[rd_ptr].sel;
`ifdef ALU_RES_FLAGS_EN
            bus.out_zero = mem[rd_ptr].zero;
            bus.out_neg  = mem[rd_ptr].neg;
`endif
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: scenario tasks plus a queue-based scoreboard of expected head entries.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int EW    = 14;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    logic [EW-1:0] exp_q[$];

    alu_result_fifo_if #(.DEPTH(DEPTH)) bus ();

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] make_exp(input logic [7:0] d, input logic c, input logic [2:0] s);
        logic z;
        logic n;
`ifdef ALU_RES_FLAGS_EN
        z = (d == 8'h00);
        n = d[7];
`else
        z = 1'b0;
        n = 1'b0;
`endif
        return {d, c, s, z, n};
    endfunction

    function automatic logic [EW-1:0] head_act();
        return {bus.out_data, bus.out_cout, bus.out_sel, bus.out_zero, bus.out_neg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; head and ready are scored before the edge, count after it.
    task automatic do_cycle(input logic pv, input logic [7:0] d, input logic c, input logic [2:0] s,
                            input logic pr, input string tag);
        logic [EW-1:0] exp_h;
        logic [EW-1:0] act;
        bit            do_push;
        bit            do_pop;
        bus.in_valid  = pv;
        bus.alu_out   = d;
        bus.alu_cout  = c;
        bus.alu_sel   = s;
        bus.out_ready = pr;
        act = head_act();
        total++;
        if (exp_q.size() > 0) begin
            exp_h = exp_q[0];
            if (bus.out_valid !== 1'b1 || act !== exp_h) begin
                bad++;
                $display("FAIL %s head: got valid=%b entry=%h want valid=1 entry=%h", tag, bus.out_valid, act, exp_h);
            end
        end else begin
            if (bus.out_valid !== 1'b0 || act !== '0) begin
                bad++;
                $display("FAIL %s empty head: got valid=%b entry=%h want valid=0 entry=0", tag, bus.out_valid, act);
            end
        end
        total++;
        if (bus.in_ready !== (exp_q.size() < DEPTH)) begin
            bad++;
            $display("FAIL %s in_ready: got %b want %b", tag, bus.in_ready, (exp_q.size() < DEPTH));
        end
        do_push = pv && (exp_q.size() < DEPTH);
        do_pop  = pr && (exp_q.size() > 0);
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(make_exp(d, c, s));
        tick();
        total++;
        if (bus.count !== 3'(exp_q.size())) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", tag, bus.count, exp_q.size());
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_out   = 8'h00;
        bus.alu_cout  = 1'b0;
        bus.alu_sel   = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        total++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset: got count=%0d ov=%b ir=%b data=%h want 0 0 1 00",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_data);
        end
    endtask

    task automatic test_single_push();
        do_cycle(1'b1, 8'h06, 1'b0, 3'b000, 1'b0, "single");
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h06 || bus.out_zero !== 1'b0 ||
            bus.out_neg !== 1'b0 || bus.count !== 3'd1) begin
            bad++;
            $display("FAIL single fields: got ov=%b data=%h z=%b n=%b count=%0d want 1 06 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_zero, bus.out_neg, bus.count);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "single_drain");
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals = '{8'h06, 8'h02, 8'h08, 8'h01};
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, vals[i], i[0], 3'(i + 1), 1'b0, "fill");
        end
        total++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill full: got count=%0d ir=%b want 4 0", bus.count, bus.in_ready);
        end
        do_cycle(1'b1, 8'hAA, 1'b1, 3'b111, 1'b0, "fill_over");
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.out_data !== vals[i]) begin
                bad++;
                $display("FAIL drain order %0d: got %h want %h", i, bus.out_data, vals[i]);
            end
            do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "drain");
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain empty: got ov=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 8'h11, 1'b0, 3'b001, 1'b0, "b2b_pre");
        do_cycle(1'b1, 8'h22, 1'b1, 3'b010, 1'b0, "b2b_pre");
        for (int i = 0; i < 9; i++) begin
            do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 1'b1, "b2b");
            total++;
            if (bus.count !== 3'd2) begin
                bad++;
                $display("FAIL b2b steady count: got %0d want 2", bus.count);
            end
        end
        do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "b2b_drain");
        do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "b2b_drain");
    endtask

    task automatic test_flags();
        logic exp_flag;
`ifdef ALU_RES_FLAGS_EN
        exp_flag = 1'b1;
`else
        exp_flag = 1'b0;
`endif
        do_cycle(1'b1, 8'h00, 1'b0, 3'b100, 1'b0, "flag_zero");
        total++;
        if (bus.out_zero !== exp_flag || bus.out_neg !== 1'b0) begin
            bad++;
            $display("FAIL flag zero: got z=%b n=%b want z=%b n=0", bus.out_zero, bus.out_neg, exp_flag);
        end
        do_cycle(1'b1, 8'hFE, 1'b1, 3'b101, 1'b1, "flag_neg");
        total++;
        if (bus.out_neg !== exp_flag || bus.out_zero !== 1'b0) begin
            bad++;
            $display("FAIL flag neg: got z=%b n=%b want z=0 n=%b", bus.out_zero, bus.out_neg, exp_flag);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "flag_drain");
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "empty_pop");
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 8'(8'h30 + i), 1'b0, 3'(i), 1'b0, "mid_fill");
        end
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.alu_out   = 8'h55;
        bus.out_ready = 1'b1;
        tick();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        total++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            bad++;
            $display("FAIL mid reset: got count=%0d ov=%b data=%h want 0 0 00", bus.count, bus.out_valid, bus.out_data);
        end
        do_cycle(1'b1, 8'h04, 1'b0, 3'b010, 1'b0, "post_reset");
        total++;
        if (bus.out_data !== 8'h04 || bus.count !== 3'd1) begin
            bad++;
            $display("FAIL post reset head: got data=%h count=%0d want 04 1", bus.out_data, bus.count);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "post_drain");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
        end
        while (exp_q.size() > 0) begin
            do_cycle(1'b0, 8'h00, 1'b0, 3'b000, 1'b1, "random_drain");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_flags();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
